// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_tap_sequencer
// Description : Sample delay line and coefficient store that sweeps taps
//               (k, C[k], x[n-k]) out to a downstream MAC per accepted sample.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_sequencer #(
    parameter int COEF_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int NTAPS      = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din_valid,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         coe_we,
    input  logic        [ADDR_WIDTH-1:0] coe_wa,
    input  logic signed [COEF_WIDTH-1:0] coe_wd,
    output logic                         en,
    output logic        [ADDR_WIDTH-1:0] ad,
    output logic signed [COEF_WIDTH-1:0] coe,
    output logic signed [DATA_WIDTH-1:0] pip,
    output logic                         busy,
    output logic                         sweep_done,
    output logic                         ovf
);

    localparam int                    c_DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_TAP  = ADDR_WIDTH'(NTAPS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {ADDR_WIDTH{1'b1}};

    localparam logic [1:0] c_INIT  = 2'd0;
    localparam logic [1:0] c_IDLE  = 2'd1;
    localparam logic [1:0] c_SWEEP = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_k;
    logic [ADDR_WIDTH-1:0] r_init_addr;

    logic signed [DATA_WIDTH-1:0] r_dline [c_DEPTH];
    logic signed [COEF_WIDTH-1:0] r_coef  [c_DEPTH];

    logic                         w_accept;
    logic                         w_rd;
    logic [ADDR_WIDTH-1:0]        w_rd_addr;
    logic                         w_dl_we;
    logic [ADDR_WIDTH-1:0]        w_dl_wa;
    logic signed [DATA_WIDTH-1:0] w_dl_wd;

    assign busy      = (r_state != c_IDLE);
    assign w_accept  = (r_state == c_IDLE) && din_valid;
    assign w_rd      = (r_state == c_SWEEP);
    assign w_rd_addr = r_base - r_k;

    // Single delay-line write port shared by the INIT clear and sample capture.
    always_comb begin
        w_dl_we = 1'b0;
        w_dl_wa = r_init_addr;
        w_dl_wd = '0;
        if (r_state == c_INIT) begin
            w_dl_we = 1'b1;
        end else if (w_accept) begin
            w_dl_we = 1'b1;
            w_dl_wa = r_wp;
            w_dl_wd = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_INIT;
            r_wp        <= '0;
            r_base      <= '0;
            r_k         <= '0;
            r_init_addr <= '0;
        end else begin
            case (r_state)
                c_INIT: begin
                    r_init_addr <= r_init_addr + 1'b1;
                    if (r_init_addr == c_LAST_ADDR) begin
                        r_state <= c_IDLE;
                    end
                end
                c_IDLE: begin
                    if (din_valid) begin
                        r_base  <= r_wp;
                        r_wp    <= r_wp + 1'b1;
                        r_k     <= '0;
                        r_state <= c_SWEEP;
                    end
                end
                c_SWEEP: begin
                    r_k <= r_k + 1'b1;
                    if (r_k == c_LAST_TAP) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: r_state <= c_IDLE;
                default: r_state <= c_INIT;
            endcase
        end
    end

    // Storage arrays carry no reset; coefficients survive rst, delay line is cleared by INIT.
    always_ff @(posedge clk) begin
        if (w_dl_we) begin
            r_dline[w_dl_wa] <= w_dl_wd;
        end
        if (coe_we) begin
            r_coef[coe_wa] <= coe_wd;
        end
    end

    // The RAM read registers double as the output registers, so they hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            en         <= 1'b0;
            ad         <= '0;
            coe        <= '0;
            pip        <= '0;
            sweep_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            en         <= w_rd;
            sweep_done <= w_rd && (r_k == c_LAST_TAP);
            if (w_rd) begin
                ad  <= r_k;
                coe <= r_coef[r_k];
                pip <= r_dline[w_rd_addr];
            end
            if (din_valid && busy) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
